// File: rtl/bespoke_pkg.sv
// Shared element types for the matvec datapath.
// Holds the element width and the signed element type.
package bespoke_pkg;

    localparam int ELEM_W = 10;

    typedef logic signed [ELEM_W-1:0] elem_t;

endpackage

// File: rtl/pipe_vector_packer.sv
// Serial element stream to parallel vector, double-buffered (fill + output).
// Optional early completion via in_last when PACKER_LAST_EN is defined.
module pipe_vector_packer
    import bespoke_pkg::*;
#(
    parameter int Elements = 12
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  elem_t                  in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
`ifdef PACKER_LAST_EN
    input  logic                   in_last,
`endif
    output elem_t [Elements-1:0]   out_vec,
    output logic                   out_valid,
    input  logic                   out_ready
);

    localparam int IDX_W = (Elements > 2) ? $clog2(Elements) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(Elements - 1);

    elem_t [Elements-1:0] fill;
    elem_t [Elements-1:0] fill_wr;
    logic [IDX_W-1:0]     idx;
    logic                 pending;
    logic                 accept;
    logic                 o_free;
    logic                 last_hit;
    logic                 complete;
    logic                 load;

`ifdef PACKER_LAST_EN
    assign last_hit = in_last;
`else
    assign last_hit = 1'b0;
`endif

    assign in_ready = !pending;
    assign accept   = in_valid && !pending;
    assign o_free   = !out_valid || out_ready;
    assign complete = accept && ((idx == LAST) || last_hit);
    assign load     = o_free && (pending || complete);

    // Fill register with this cycle's element merged in; while pending
    // no element is accepted, so this is just the parked vector.
    always_comb begin
        fill_wr = fill;
        if (accept) begin
            fill_wr[idx] = in_data;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            fill      <= '0;
            idx       <= '0;
            pending   <= 1'b0;
            out_vec   <= '0;
            out_valid <= 1'b0;
        end else if (load) begin
            out_vec   <= fill_wr;
            out_valid <= 1'b1;
            fill      <= '0;
            idx       <= '0;
            pending   <= 1'b0;
        end else begin
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (accept) begin
                fill <= fill_wr;
                if (complete) begin
                    pending <= 1'b1;
                end else begin
                    idx <= idx + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_pipe_vector_packer.sv
// Directed bench for pipe_vector_packer with a queue-based vector model.
// Also exercises a two-element instance under output toggling.
module tb_pipe_vector_packer;
    import bespoke_pkg::*;

    typedef elem_t [11:0] v12_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    elem_t din;
    logic  vin;
    logic  rdy;
    logic  ov;
    logic  ordy;
    v12_t  vec;
`ifdef PACKER_LAST_EN
    logic  last1 = 1'b0;
`endif

    elem_t        d2;
    logic         v2;
    logic         r2;
    logic         ov2;
    logic         or2;
    elem_t [1:0]  vec2;

    pipe_vector_packer #(.Elements(12)) dut (
        .clk_in   (clk),
        .rst_in   (rst),
        .in_data  (din),
        .in_valid (vin),
        .in_ready (rdy),
`ifdef PACKER_LAST_EN
        .in_last  (last1),
`endif
        .out_vec  (vec),
        .out_valid(ov),
        .out_ready(ordy)
    );

    pipe_vector_packer #(.Elements(2)) dut2 (
        .clk_in   (clk),
        .rst_in   (rst),
        .in_data  (d2),
        .in_valid (v2),
        .in_ready (r2),
`ifdef PACKER_LAST_EN
        .in_last  (1'b0),
`endif
        .out_vec  (vec2),
        .out_valid(ov2),
        .out_ready(or2)
    );

    int    total = 0;
    int    bad = 0;
    int    nout = 0;
    int    nout2 = 0;
    int    acc2 = 0;
    int    nrd_low = 0;
    v12_t  exp_q[$];
    elem_t cur[$];
    elem_t sent2[$];
    elem_t firsts[$];
    v12_t  last_out;
    v12_t  vtmp;
    logic  lb;

    task automatic chk(input string n, input int a, input int e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", n, a, e);
        end
    endtask

    task automatic chkv(input string n, input v12_t a, input v12_t e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %h want %h", n, a, e);
        end
    endtask

    // Model: a vector is complete after 12 accepted elements (or in_last);
    // completed-but-unconsumed vectors sit in exp_q. One held means
    // out_valid, two held means the fill side is full.
    always @(negedge clk) begin
        if (!rst) begin
            chk("out_valid", int'(ov), int'(exp_q.size() > 0));
            chk("in_ready", int'(rdy), int'(exp_q.size() < 2));
            if (ov && exp_q.size() > 0) chkv("out_vec", vec, exp_q[0]);
            if (!rdy) nrd_low++;
            if (ov && ordy) begin
                nout++;
                last_out = vec;
                firsts.push_back(vec[0]);
                if (exp_q.size() > 0) void'(exp_q.pop_front());
            end
`ifdef PACKER_LAST_EN
            lb = last1;
`else
            lb = 1'b0;
`endif
            if (vin && rdy) begin
                cur.push_back(din);
                if (cur.size() == 12 || lb) begin
                    vtmp = '0;
                    foreach (cur[i]) vtmp[i] = cur[i];
                    exp_q.push_back(vtmp);
                    cur.delete();
                end
            end
            if (ov2 && or2) begin
                nout2++;
                if (sent2.size() >= 2) begin
                    chk("e2_elem0", int'(vec2[0]), int'(sent2[0]));
                    chk("e2_elem1", int'(vec2[1]), int'(sent2[1]));
                    void'(sent2.pop_front());
                    void'(sent2.pop_front());
                end else begin
                    chk("e2_underflow", sent2.size(), 2);
                end
            end
            if (v2 && r2) begin
                sent2.push_back(d2);
                acc2++;
            end
        end
    end

    task automatic send(input int v);
        int n;
        n = 0;
        din = elem_t'(v);
        vin = 1'b1;
        @(negedge clk);
        while (!rdy && n < 200) begin
            n++;
            @(negedge clk);
        end
        chk("send_accept", int'(rdy), 1);
        @(posedge clk);
        #1;
        vin = 1'b0;
`ifdef PACKER_LAST_EN
        last1 = 1'b0;
`endif
    endtask

    task automatic wait_outs(input int n);
        int k;
        k = 0;
        while (nout < n && k < 200) begin
            k++;
            @(negedge clk);
        end
        chk("wait_outs", nout, n);
        @(posedge clk);
        #1;
    endtask

    task automatic gap(input int g);
        repeat (g) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic rd;
        v12_t lv;
        din = '0;
        vin = 1'b0;
        ordy = 1'b1;
        d2 = '0;
        v2 = 1'b0;
        or2 = 1'b0;
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", int'(ov), 0);
        chk("rst_in_ready", int'(rdy), 1);
        chkv("rst_out_vec", vec, '0);
        chk("rst_out_valid2", int'(ov2), 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // stream 1..12, consumer always ready
        nrd_low = 0;
        for (int i = 1; i <= 12; i++) send(i);
        wait_outs(1);
        chk("t1_ready_low", nrd_low, 0);
        chk("t1_first", int'(last_out[0]), 1);
        chk("t1_last", int'(last_out[11]), 12);

        // consumer stalled across two vectors
        ordy = 1'b0;
        for (int i = 1; i <= 24; i++) send(i);
        @(negedge clk);
        chk("t2_ready_drop", int'(rdy), 0);
        gap(4);
        ordy = 1'b1;
        wait_outs(3);
        chk("t2_vec1", int'(firsts[1]), 1);
        chk("t2_vec2", int'(firsts[2]), 13);
        chk("t2_vec2_end", int'(last_out[11]), 24);

        // input gaps
        for (int i = 0; i < 36; i++) begin
            gap($urandom_range(0, 2));
            send(100 + i);
        end
        wait_outs(6);
        chk("t3_third_first", int'(firsts[5]), 124);
        chk("t3_third_last", int'(last_out[11]), 135);

        // async reset mid-vector
        for (int i = 0; i < 5; i++) send(300 + i);
        #2 rst = 1'b1;
        cur.delete();
        exp_q.delete();
        sent2.delete();
        @(negedge clk);
        chk("t4_rst_valid", int'(ov), 0);
        chk("t4_rst_ready", int'(rdy), 1);
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 1; i <= 12; i++) send(i);
        wait_outs(7);
        chk("t4_first", int'(last_out[0]), 1);
        chk("t4_fifth", int'(last_out[4]), 5);
        chk("t4_last", int'(last_out[11]), 12);

`ifdef PACKER_LAST_EN
        send(-3);
        send(7);
        last1 = 1'b1;
        send(511);
        wait_outs(8);
        lv = '0;
        lv[0] = elem_t'(-3);
        lv[1] = elem_t'(7);
        lv[2] = elem_t'(511);
        chkv("t5_short_vec", last_out, lv);
        for (int i = 1; i <= 12; i++) send(i);
        wait_outs(9);
        chk("t5_next_first", int'(last_out[0]), 1);
        chk("t5_next_last", int'(last_out[11]), 12);
`endif

        // two-element instance, output ready toggling every cycle
        v2 = 1'b1;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            rd = r2;
            @(posedge clk);
            #1;
            if (rd) d2 = elem_t'(d2 + 1);
            or2 = ~or2;
        end
        v2 = 1'b0;
        or2 = 1'b1;
        gap(6);
        chk("t6_drained", sent2.size(), 0);
        chk("t6_count", nout2 * 2, acc2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
